// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-N demultiplexer.
// The optional error counter width is used when DEMUX_ERR_CNT_EN is defined.
package demux_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ERR_CNT_W      = 16;

  // Smallest r with 2**r >= v; used to validate the select width at elaboration.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(v)) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
// A load wins over a drain so a full channel can refill every cycle.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1ton_reg.sv
// Registered 1-to-N demultiplexer with a per-channel valid/ready holding slot.
// Define DEMUX_ERR_CNT_EN to add a saturating count of out-of-range selects (err_cnt).
module demux_1ton_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W_DEFAULT,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned SEL_W = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]   err_cnt
`endif
);

  if (N_OUT < 2 || N_OUT > 16) begin : g_bad_n_out
    $error("demux_1ton_reg: N_OUT must be in 2..16");
  end
  if (SEL_W < clog2(N_OUT)) begin : g_bad_sel_w
    $error("demux_1ton_reg: SEL_W too narrow for N_OUT");
  end

  logic             accept;
  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] drain;

  // Ready follows the addressed slot; unmatched selects are always taken and dropped.
  always_comb begin
    in_ready = 1'b1;
    for (int k = 0; k < int'(N_OUT); k++) begin
      if (in_sel == SEL_W'(k)) begin
        in_ready = !out_valid[k] | out_ready[k];
      end
    end
  end

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // One-hot load decode of the accepted word.
  always_comb begin
    load = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      load[k] = accept & (in_sel == SEL_W'(k));
    end
  end

  for (genvar k = 0; k < int'(N_OUT); k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .drain (drain[k]),
      .din   (in_data),
      .data  (out_data[k*WIDTH +: WIDTH]),
      .valid (out_valid[k])
    );
  end

`ifdef DEMUX_ERR_CNT_EN
  logic sel_in_range;
  logic oor_accept;

  assign sel_in_range = 32'(in_sel) < N_OUT;
  assign oor_accept   = accept & ~sel_in_range;

  // Saturating count of discarded out-of-range words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (oor_accept && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux_1ton_reg.sv
// Directed bench for demux_1ton_reg: a 2-channel instance driven from a vector
// table plus a 3-channel instance for out-of-range selects and reset corners.
module tb_demux_1ton_reg;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [W-1:0]   in_data;
  logic           in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] out_data;
  logic [1:0]     out_valid;
  logic [1:0]     out_ready;

  logic [W-1:0]   in3_data;
  logic [1:0]     in3_sel;
  logic           in3_valid;
  logic           in3_ready;
  logic [3*W-1:0] out3_data;
  logic [2:0]     out3_valid;
  logic [2:0]     out3_ready;

`ifdef DEMUX_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic [15:0] err_cnt3;
`endif

  demux_1ton_reg #(.WIDTH(W), .N_OUT(2), .SEL_W(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  demux_1ton_reg #(.WIDTH(W), .N_OUT(3), .SEL_W(2)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in3_data),
    .in_sel    (in3_sel),
    .in_valid  (in3_valid),
    .in_ready  (in3_ready),
    .out_data  (out3_data),
    .out_valid (out3_valid),
    .out_ready (out3_ready)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt3)
`endif
  );

  typedef struct {
    logic          valid;
    logic          sel;
    logic [W-1:0]  data;
    logic [1:0]    ordy;
    logic          exp_rdy;
    logic [1:0]    exp_ov;
    logic [2*W-1:0] exp_od;
  } vec_t;

  vec_t vecs[14];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // valid sel data ordy | exp in_ready, exp out_valid, exp out_data {ch1,ch0}
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 2'b11, 1'b1, 2'b01, {32'h0000_0000, 32'h0000_0000}};
    vecs[1]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 2'b11, 1'b1, 2'b10, {32'hFFFF_FFFF, 32'h0000_0000}};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0000, 2'b11, 1'b1, 2'b00, {32'hFFFF_FFFF, 32'h0000_0000}};
    vecs[3]  = '{1'b1, 1'b0, 32'hA5A5_A5A5, 2'b00, 1'b1, 2'b01, {32'hFFFF_FFFF, 32'hA5A5_A5A5}};
    vecs[4]  = '{1'b1, 1'b0, 32'h1234_5678, 2'b00, 1'b0, 2'b01, {32'hFFFF_FFFF, 32'hA5A5_A5A5}};
    vecs[5]  = '{1'b1, 1'b0, 32'h1234_5678, 2'b01, 1'b1, 2'b01, {32'hFFFF_FFFF, 32'h1234_5678}};
    vecs[6]  = '{1'b1, 1'b0, 32'hCAFE_F00D, 2'b00, 1'b0, 2'b01, {32'hFFFF_FFFF, 32'h1234_5678}};
    vecs[7]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b1, 2'b11, {32'hDEAD_BEEF, 32'h1234_5678}};
    vecs[8]  = '{1'b0, 1'b1, 32'h0BAD_0BAD, 2'b00, 1'b0, 2'b11, {32'hDEAD_BEEF, 32'h1234_5678}};
    vecs[9]  = '{1'b1, 1'b0, 32'h5555_5555, 2'b10, 1'b0, 2'b01, {32'hDEAD_BEEF, 32'h1234_5678}};
    vecs[10] = '{1'b1, 1'b1, 32'hAAAA_AAAA, 2'b01, 1'b1, 2'b10, {32'hAAAA_AAAA, 32'h1234_5678}};
    vecs[11] = '{1'b1, 1'b1, 32'h0123_4567, 2'b10, 1'b1, 2'b10, {32'h0123_4567, 32'h1234_5678}};
    vecs[12] = '{1'b1, 1'b0, 32'h89AB_CDEF, 2'b10, 1'b1, 2'b01, {32'h0123_4567, 32'h89AB_CDEF}};
    vecs[13] = '{1'b1, 1'b1, 32'h7777_7777, 2'b00, 1'b1, 2'b11, {32'h7777_7777, 32'h89AB_CDEF}};

    rst_n      = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out_ready  = '0;
    in3_data   = '0;
    in3_sel    = '0;
    in3_valid  = 1'b0;
    out3_ready = '0;

    // Reset held for three cycles, then released while idle
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 128'(out_valid), 128'(2'b00));
    check("rst out_data", 128'(out_data), 128'(0));
    check("rst in_ready", 128'(in_ready), 128'(1'b1));
    check("rst out3_valid", 128'(out3_valid), 128'(3'b000));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle out_valid", 128'(out_valid), 128'(2'b00));
    check("idle out_data", 128'(out_data), 128'(0));
    check("idle in_ready", 128'(in_ready), 128'(1'b1));
    check("idle in3_ready", 128'(in3_ready), 128'(1'b1));
`ifdef DEMUX_ERR_CNT_EN
    check("idle err_cnt3", 128'(err_cnt3), 128'(0));
`endif

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid  = vecs[i].valid;
      in_sel    = vecs[i].sel;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(vecs[i].exp_ov));
      check($sformatf("vec%0d out_data", i), 128'(out_data), 128'(vecs[i].exp_od));
    end

    // Asynchronous reset between edges while both channels are full
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 128'(out_valid), 128'(2'b00));
    check("async rst out_data", 128'(out_data), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post rst out_valid", 128'(out_valid), 128'(2'b00));
`ifdef DEMUX_ERR_CNT_EN
    check("err_cnt in-range only", 128'(err_cnt), 128'(0));
`endif

    // Three channels: fill and stall channel 2, then send five out-of-range words
    @(negedge clk);
    in3_valid  = 1'b1;
    in3_sel    = 2'd2;
    in3_data   = 32'hC0FF_EE00;
    out3_ready = 3'b000;
    @(posedge clk);
    #1;
    check("n3 load ch2 valid", 128'(out3_valid), 128'(3'b100));
    check("n3 load ch2 data", 128'(out3_data), 128'({32'hC0FF_EE00, 64'h0}));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in3_valid = 1'b1;
      in3_sel   = 2'd3;
      in3_data  = 32'h0000_1000 + 32'(i);
      #1;
      check($sformatf("oor%0d in_ready", i), 128'(in3_ready), 128'(1'b1));
      @(posedge clk);
      #1;
      check($sformatf("oor%0d out_valid", i), 128'(out3_valid), 128'(3'b100));
      check($sformatf("oor%0d out_data", i), 128'(out3_data), 128'({32'hC0FF_EE00, 64'h0}));
    end
    // Out-of-range select with in_valid low is not a word
    @(negedge clk);
    in3_valid = 1'b0;
    in3_sel   = 2'd3;
    @(posedge clk);
    #1;
`ifdef DEMUX_ERR_CNT_EN
    check("err_cnt3 after 5", 128'(err_cnt3), 128'(5));
`endif
    // Stalled ch2 refuses, ch0 still accepts
    @(negedge clk);
    in3_valid = 1'b1;
    in3_sel   = 2'd2;
    in3_data  = 32'h2222_2222;
    #1;
    check("n3 ch2 stalled in_ready", 128'(in3_ready), 128'(1'b0));
    in3_sel  = 2'd0;
    in3_data = 32'h1111_1111;
    #1;
    check("n3 ch0 in_ready", 128'(in3_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    check("n3 ch0 load valid", 128'(out3_valid), 128'(3'b101));
    check("n3 ch0 load data", 128'(out3_data), 128'({32'hC0FF_EE00, 32'h0, 32'h1111_1111}));
    @(negedge clk);
    in3_valid  = 1'b0;
    out3_ready = 3'b100;
    @(posedge clk);
    #1;
    check("n3 ch2 drain valid", 128'(out3_valid), 128'(3'b001));
    check("n3 ch2 drain data held", 128'(out3_data), 128'({32'hC0FF_EE00, 32'h0, 32'h1111_1111}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
